uart_packet_parser: RTL and testbench

UART_PACKET_PARSER -- requirements
Module: uart_packet_parser

---
 rtl/uart_packet_parser.sv | 133 +++++++++++++
 tb/tb_uart_packet_parser.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_packet_parser.sv
// Parses HEADER, length, payload and additive-checksum packets from a UART byte stream.
// Failed or timed-out packets never disturb the last good packet outputs.
module uart_packet_parser #(
  parameter int         MAX_LEN        = 8,
  parameter int         TIMEOUT_CYCLES = 100000,
  parameter logic [7:0] HEADER         = 8'hA5
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [7:0]             rxData,
  input  logic                   rxDone,
  output logic                   pktValid,
  output logic [3:0]             pktLen,
  output logic [8*MAX_LEN-1:0]   pktData,
  output logic                   csumErr,
  output logic                   lenErr,
  output logic                   timeoutErr,
  output logic                   busy
);

  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, LEN, PAYLOAD, CSUM} stateT;

  stateT                state, stateNext;
  logic [3:0]           lenReg;
  logic [3:0]           idx;
  logic [7:0]           sum;
  logic [8*MAX_LEN-1:0] payBuf;
  logic [TO_W-1:0]      toCnt;
  logic                 timeoutHit, lenBad, csumOk;
  logic                 pktValidNext, csumErrNext, lenErrNext, timeoutErrNext;

  assign busy       = (state != IDLE);
  // A byte arriving in the expiry cycle wins over the timeout.
  assign timeoutHit = busy && !rxDone && (toCnt == TO_W'(TIMEOUT_CYCLES - 1));
  assign lenBad     = (rxData == 8'd0) || (rxData > 8'(MAX_LEN));
  assign csumOk     = (rxData == sum);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= stateNext;
  end

  always_comb begin
    stateNext      = state;
    pktValidNext   = 1'b0;
    csumErrNext    = 1'b0;
    lenErrNext     = 1'b0;
    timeoutErrNext = 1'b0;
    if (timeoutHit) begin
      stateNext      = IDLE;
      timeoutErrNext = 1'b1;
    end else if (rxDone) begin
      case (state)
        IDLE:    if (rxData == HEADER) stateNext = LEN;
        LEN: begin
          if (lenBad) begin
            stateNext  = IDLE;
            lenErrNext = 1'b1;
          end else begin
            stateNext  = PAYLOAD;
          end
        end
        PAYLOAD: if (idx == lenReg - 4'd1) stateNext = CSUM;
        CSUM: begin
          stateNext    = IDLE;
          pktValidNext = csumOk;
          csumErrNext  = !csumOk;
        end
        default: stateNext = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pktValid   <= 1'b0;
      csumErr    <= 1'b0;
      lenErr     <= 1'b0;
      timeoutErr <= 1'b0;
    end else begin
      pktValid   <= pktValidNext;
      csumErr    <= csumErrNext;
      lenErr     <= lenErrNext;
      timeoutErr <= timeoutErrNext;
    end
  end

  // Working buffer is cleared at each new length so unused bytes publish as zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lenReg  <= 4'd0;
      idx     <= 4'd0;
      sum     <= 8'd0;
      payBuf  <= '0;
      toCnt   <= '0;
      pktLen  <= 4'd0;
      pktData <= '0;
    end else begin
      if (!busy || rxDone || timeoutHit) toCnt <= '0;
      else                               toCnt <= toCnt + TO_W'(1);

      if (rxDone && !timeoutHit) begin
        case (state)
          LEN: begin
            if (!lenBad) begin
              lenReg <= rxData[3:0];
              sum    <= rxData;
              idx    <= 4'd0;
              payBuf <= '0;
            end
          end
          PAYLOAD: begin
            for (int i = 0; i < MAX_LEN; i++) begin
              if (idx == 4'(i)) payBuf[8*i +: 8] <= rxData;
            end
            sum <= sum + rxData;
            idx <= idx + 4'd1;
          end
          CSUM: begin
            if (csumOk) begin
              pktLen  <= lenReg;
              pktData <= payBuf;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_packet_parser.sv
// Randomised and directed bench for uart_packet_parser against a queue-based packet model.
module tb_uart_packet_parser;

  localparam int         MAXL = 8;
  localparam int         TO   = 20;
  localparam logic [7:0] HDR  = 8'hA5;
  localparam logic [3:0] ST_VALID = 4'b1000;
  localparam logic [3:0] ST_CSUM  = 4'b0100;
  localparam logic [3:0] ST_LEN   = 4'b0010;

  logic            clk = 1'b0;
  logic            rst;
  logic [7:0]      rxData;
  logic            rxDone;
  logic            pktValid, csumErr, lenErr, timeoutErr, busy;
  logic [3:0]      pktLen;
  logic [8*MAXL-1:0] pktData;

  int errors = 0;
  int checks = 0;

  // Model state: bytes of the packet in progress, and last good packet.
  logic [7:0]        cur[$];
  logic [3:0]        expLen;
  logic [8*MAXL-1:0] expData;

  uart_packet_parser #(.MAX_LEN(MAXL), .TIMEOUT_CYCLES(TO), .HEADER(HDR)) dut (
    .clk(clk), .rst(rst), .rxData(rxData), .rxDone(rxDone),
    .pktValid(pktValid), .pktLen(pktLen), .pktData(pktData),
    .csumErr(csumErr), .lenErr(lenErr), .timeoutErr(timeoutErr), .busy(busy)
  );

  always #5 clk = ~clk;

  // Returns the strobe vector {valid,csum,len,timeout} this byte should cause.
  function automatic logic [3:0] modelByte(input logic [7:0] b);
    logic [7:0] s;
    logic [3:0] r;
    r = 4'b0;
    if (cur.size() == 0) begin
      if (b == HDR) cur.push_back(b);
    end else begin
      cur.push_back(b);
      if (cur.size() == 2) begin
        if (b == 8'd0 || b > 8'(MAXL)) begin
          r = ST_LEN;
          cur.delete();
        end
      end else if (cur.size() == int'(cur[1]) + 3) begin
        s = 8'd0;
        for (int i = 1; i < cur.size() - 1; i++) s = s + cur[i];
        if (s == b) begin
          r = ST_VALID;
          expLen  = cur[1][3:0];
          expData = '0;
          for (int i = 0; i < int'(cur[1]); i++) expData[8*i +: 8] = cur[i+2];
        end else begin
          r = ST_CSUM;
        end
        cur.delete();
      end
    end
    return r;
  endfunction

  function automatic int modelIdle(input int n);
    if (cur.size() != 0 && n >= TO) begin
      cur.delete();
      return TO;
    end
    return 0;
  endfunction

  task automatic driveByte(input logic [7:0] b, output logic [3:0] st, output logic bz);
    rxData = b;
    rxDone = 1'b1;
    @(negedge clk);
    rxDone = 1'b0;
    st = {pktValid, csumErr, lenErr, timeoutErr};
    bz = busy;
  endtask

  task automatic idleFor(input int n, output int toAt, output int extra);
    toAt  = 0;
    extra = 0;
    for (int j = 1; j <= n; j++) begin
      @(negedge clk);
      if (timeoutErr) begin
        if (toAt == 0) toAt = j;
        else           extra++;
      end
      if (pktValid || csumErr || lenErr) extra++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; rxDone = 1'b0; rxData = 8'h00;
    cur.delete(); expLen = 4'd0; expData = '0;
    repeat (2) @(negedge clk);
    checks++; if ({pktValid, csumErr, lenErr, timeoutErr} !== 4'b0) begin errors++; $display("[TB] FAIL reset.strobes got %b want 0000", {pktValid, csumErr, lenErr, timeoutErr}); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset.busy got %b want 0", busy); end
    checks++; if (pktLen !== 4'd0) begin errors++; $display("[TB] FAIL reset.pktLen got %0d want 0", pktLen); end
    checks++; if (pktData !== 64'h0) begin errors++; $display("[TB] FAIL reset.pktData got %h want 0", pktData); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_good_packet();
    logic [7:0] seq[$] = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h69};
    logic [3:0] st, expSt;
    logic bz;
    int toAt, extra;
    foreach (seq[i]) begin
      expSt = modelByte(seq[i]);
      driveByte(seq[i], st, bz);
      checks++; if (st !== expSt) begin errors++; $display("[TB] FAIL good.strobe byte %0d got %b want %b", i, st, expSt); end
      checks++; if (bz !== (cur.size() != 0)) begin errors++; $display("[TB] FAIL good.busy byte %0d got %b want %b", i, bz, cur.size() != 0); end
    end
    checks++; if (st !== ST_VALID) begin errors++; $display("[TB] FAIL good.final got %b want %b", st, ST_VALID); end
    checks++; if (pktLen !== 4'd3) begin errors++; $display("[TB] FAIL good.pktLen got %0d want 3", pktLen); end
    checks++; if (pktData !== 64'h0000000000332211) begin errors++; $display("[TB] FAIL good.pktData got %h want 332211", pktData); end
    idleFor(3, toAt, extra);
    checks++; if (extra + toAt !== 0) begin errors++; $display("[TB] FAIL good.oneCycle got %0d extra strobes want 0", extra + toAt); end
  endtask

  task automatic test_csum_err();
    logic [7:0] seq[$] = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h68};
    logic [3:0] st, expSt;
    logic bz;
    foreach (seq[i]) begin
      expSt = modelByte(seq[i]);
      driveByte(seq[i], st, bz);
      checks++; if (st !== expSt) begin errors++; $display("[TB] FAIL csum.strobe byte %0d got %b want %b", i, st, expSt); end
    end
    checks++; if (st !== ST_CSUM) begin errors++; $display("[TB] FAIL csum.final got %b want %b", st, ST_CSUM); end
    checks++; if (pktLen !== 4'd3) begin errors++; $display("[TB] FAIL csum.pktLenHeld got %0d want 3", pktLen); end
    checks++; if (pktData !== 64'h0000000000332211) begin errors++; $display("[TB] FAIL csum.pktDataHeld got %h want 332211", pktData); end
  endtask

  task automatic test_len_err();
    logic [7:0] seq[$] = '{8'hA5, 8'h00, 8'hA5, 8'h09};
    logic [3:0] st, expSt;
    logic bz;
    int lenPulses = 0;
    foreach (seq[i]) begin
      expSt = modelByte(seq[i]);
      driveByte(seq[i], st, bz);
      if (st == ST_LEN) lenPulses++;
      checks++; if (st !== expSt) begin errors++; $display("[TB] FAIL len.strobe byte %0d got %b want %b", i, st, expSt); end
      checks++; if (bz !== (i % 2 == 0)) begin errors++; $display("[TB] FAIL len.busy byte %0d got %b want %b", i, bz, i % 2 == 0); end
    end
    checks++; if (lenPulses !== 2) begin errors++; $display("[TB] FAIL len.pulses got %0d want 2", lenPulses); end
  endtask

  task automatic test_timeout();
    logic [7:0] pre[$]  = '{8'hA5, 8'h02, 8'h11};
    logic [7:0] post[$] = '{8'hA5, 8'h01, 8'h7F, 8'h80};
    logic [3:0] st, expSt;
    logic bz;
    int toAt, extra, expTo;
    foreach (pre[i]) begin
      expSt = modelByte(pre[i]);
      driveByte(pre[i], st, bz);
      checks++; if (st !== expSt) begin errors++; $display("[TB] FAIL to.preStrobe byte %0d got %b want %b", i, st, expSt); end
    end
    expTo = modelIdle(TO + 3);
    idleFor(TO + 3, toAt, extra);
    checks++; if (toAt !== TO) begin errors++; $display("[TB] FAIL to.pulseAt got %0d want %0d", toAt, TO); end
    checks++; if (extra !== 0) begin errors++; $display("[TB] FAIL to.extra got %0d want 0", extra); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL to.busy got %b want 0", busy); end
    checks++; if (toAt !== expTo) begin errors++; $display("[TB] FAIL to.model got %0d want %0d", toAt, expTo); end
    foreach (post[i]) begin
      expSt = modelByte(post[i]);
      driveByte(post[i], st, bz);
      checks++; if (st !== expSt) begin errors++; $display("[TB] FAIL to.postStrobe byte %0d got %b want %b", i, st, expSt); end
    end
    checks++; if (pktLen !== 4'd1) begin errors++; $display("[TB] FAIL to.pktLen got %0d want 1", pktLen); end
    checks++; if (pktData !== 64'h7F) begin errors++; $display("[TB] FAIL to.pktData got %h want 7f", pktData); end
  endtask

  task automatic test_timeout_priority();
    logic [7:0] seq[$] = '{8'hA5, 8'h01, 8'h55, 8'h56};
    logic [3:0] st, expSt;
    logic bz;
    int toAt, extra;
    foreach (seq[i]) begin
      expSt = modelByte(seq[i]);
      driveByte(seq[i], st, bz);
      checks++; if (st !== expSt) begin errors++; $display("[TB] FAIL prio.strobe byte %0d got %b want %b", i, st, expSt); end
      if (i < 3) begin
        idleFor(TO - 1, toAt, extra);
        checks++; if (toAt + extra !== 0) begin errors++; $display("[TB] FAIL prio.noTimeout byte %0d got %0d strobes want 0", i, toAt + extra); end
      end
    end
    checks++; if (pktData !== 64'h55) begin errors++; $display("[TB] FAIL prio.pktData got %h want 55", pktData); end
  endtask

  task automatic test_noise_max();
    logic [7:0] seq[$] = '{8'h00, 8'hFF, 8'h5A, 8'hA5, 8'h08, 8'h01, 8'h02, 8'h03,
                           8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h2C};
    logic [3:0] st, expSt;
    logic bz;
    int toAt, extra;
    foreach (seq[i]) begin
      expSt = modelByte(seq[i]);
      driveByte(seq[i], st, bz);
      checks++; if (st !== expSt) begin errors++; $display("[TB] FAIL noise.strobe byte %0d got %b want %b", i, st, expSt); end
      if (i < 3) begin
        checks++; if (bz !== 1'b0) begin errors++; $display("[TB] FAIL noise.busy byte %0d got %b want 0", i, bz); end
      end
      idleFor(i % 3, toAt, extra);
    end
    checks++; if (pktLen !== 4'd8) begin errors++; $display("[TB] FAIL noise.pktLen got %0d want 8", pktLen); end
    checks++; if (pktData !== 64'h0807060504030201) begin errors++; $display("[TB] FAIL noise.pktData got %h want 0807060504030201", pktData); end
  endtask

  task automatic test_mid_reset();
    logic [7:0] pre[$]  = '{8'hA5, 8'h04, 8'h11};
    logic [7:0] post[$] = '{8'hA5, 8'h01, 8'h10, 8'h11};
    logic [3:0] st, expSt;
    logic bz;
    int toAt, extra;
    foreach (pre[i]) void'(modelByte(pre[i]));
    foreach (pre[i]) driveByte(pre[i], st, bz);
    rst = 1'b1;
    cur.delete(); expLen = 4'd0; expData = '0;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL mrst.busy got %b want 0", busy); end
    checks++; if (pktData !== 64'h0) begin errors++; $display("[TB] FAIL mrst.pktData got %h want 0", pktData); end
    rst = 1'b0;
    idleFor(TO + 2, toAt, extra);
    checks++; if (toAt + extra !== 0) begin errors++; $display("[TB] FAIL mrst.noStrobe got %0d want 0", toAt + extra); end
    foreach (post[i]) begin
      expSt = modelByte(post[i]);
      driveByte(post[i], st, bz);
      checks++; if (st !== expSt) begin errors++; $display("[TB] FAIL mrst.strobe byte %0d got %b want %b", i, st, expSt); end
    end
    checks++; if (pktData !== 64'h10) begin errors++; $display("[TB] FAIL mrst.pktData2 got %h want 10", pktData); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] seq[$] = '{8'hA5, 8'h02, 8'hA5, 8'h01, 8'hA8,
                           8'hA5, 8'h01, 8'hFF, 8'h00};
    logic [3:0] st, expSt;
    logic bz;
    int valids = 0;
    foreach (seq[i]) begin
      expSt = modelByte(seq[i]);
      driveByte(seq[i], st, bz);
      if (st == ST_VALID) valids++;
      checks++; if (st !== expSt) begin errors++; $display("[TB] FAIL b2b.strobe byte %0d got %b want %b", i, st, expSt); end
      checks++; if (pktData !== expData) begin errors++; $display("[TB] FAIL b2b.pktData byte %0d got %h want %h", i, pktData, expData); end
    end
    checks++; if (valids !== 2) begin errors++; $display("[TB] FAIL b2b.valids got %0d want 2", valids); end
  endtask

  task automatic test_random();
    logic [7:0] seq[$];
    logic [3:0] st, expSt;
    logic [7:0] s, len;
    logic bz;
    int kind, g, toAt, extra, expTo;
    for (int p = 0; p < 40; p++) begin
      seq.delete();
      kind = int'($urandom_range(0, 4));
      len  = 8'($urandom_range(1, MAXL));
      if (kind == 3) begin
        for (int k = 0; k < 3; k++) seq.push_back(8'($urandom));
      end else begin
        seq.push_back(HDR);
        if (kind == 2) seq.push_back(($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom_range(MAXL + 1, 255)));
        else           seq.push_back(len);
        if (kind != 2) begin
          s = len;
          for (int k = 0; k < ((kind == 4) ? int'(len) - 1 : int'(len)); k++) begin
            seq.push_back(8'($urandom));
            s = s + seq[seq.size()-1];
          end
          if (kind == 0) seq.push_back(s);
          if (kind == 1) seq.push_back(s ^ 8'($urandom_range(1, 255)));
        end
      end
      foreach (seq[i]) begin
        expSt = modelByte(seq[i]);
        driveByte(seq[i], st, bz);
        checks++; if (st !== expSt) begin errors++; $display("[TB] FAIL rnd.strobe pkt %0d byte %0d got %b want %b", p, i, st, expSt); end
        checks++; if (bz !== (cur.size() != 0)) begin errors++; $display("[TB] FAIL rnd.busy pkt %0d byte %0d got %b want %b", p, i, bz, cur.size() != 0); end
        checks++; if (pktLen !== expLen) begin errors++; $display("[TB] FAIL rnd.pktLen pkt %0d got %0d want %0d", p, pktLen, expLen); end
        checks++; if (pktData !== expData) begin errors++; $display("[TB] FAIL rnd.pktData pkt %0d got %h want %h", p, pktData, expData); end
        g = ($urandom_range(0, 7) == 0) ? TO - 1 : int'($urandom_range(0, 2));
        if (i == seq.size() - 1) g = (kind == 4) ? TO + 2 : int'($urandom_range(0, 3));
        expTo = modelIdle(g);
        idleFor(g, toAt, extra);
        checks++; if (toAt !== expTo) begin errors++; $display("[TB] FAIL rnd.timeout pkt %0d byte %0d got %0d want %0d", p, i, toAt, expTo); end
        checks++; if (extra !== 0) begin errors++; $display("[TB] FAIL rnd.extra pkt %0d byte %0d got %0d want 0", p, i, extra); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_good_packet();
    test_csum_err();
    test_len_err();
    test_timeout();
    test_timeout_priority();
    test_noise_max();
    test_mid_reset();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
